// File: rtl/fp_minmax_issue.sv
// Operand issue buffer in front of an FP min/max stage: a small FIFO that
// precomputes NaN and illegal-op flags at push time and counts issued ops.
module fp_minmax_issue #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_op_a,
    input  logic [31:0]      in_op_b,
    input  logic [2:0]       in_rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_op_a,
    output logic [31:0]      out_op_b,
    output logic [2:0]       out_rm,
    output logic             out_a_nan,
    output logic             out_b_nan,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issued_cnt
);
    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        logic        a_nan;
        logic        b_nan;
        logic        illegal;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    entry_t           new_entry_s;
    entry_t           head_s;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic             push_s;
    logic             pop_s;

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + {{(PTR_W-1){1'b0}}, 1'b1};
    endfunction

    // Handshake decode; in_ready looks only at the registered count, never at out_ready.
    always_comb begin
        in_ready  = !rst && (count_q < (PTR_W+1)'(DEPTH));
        out_valid = !rst && (count_q != {(PTR_W+1){1'b0}});
        push_s    = in_valid && in_ready;
        pop_s     = out_valid && out_ready;
    end

    // Next-state: storage write, pointer advance, occupancy and issue counter.
    always_comb begin
        mem_d             = mem_q;
        wr_ptr_d          = wr_ptr_q;
        rd_ptr_d          = rd_ptr_q;
        count_d           = count_q;
        issued_d          = issued_q;
        new_entry_s.a       = in_op_a;
        new_entry_s.b       = in_op_b;
        new_entry_s.rm      = in_rm;
        new_entry_s.a_nan   = is_nan(in_op_a);
        new_entry_s.b_nan   = is_nan(in_op_b);
        new_entry_s.illegal = (in_rm != 3'b000) && (in_rm != 3'b001);
        if (push_s) begin
            mem_d[wr_ptr_q] = new_entry_s;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
            issued_d = issued_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // State registers; reset wins over any push or pop and discards buffered entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
            issued_q <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            issued_q <= issued_d;
        end
    end

    // Head entry straight from storage; forced to zero while reset is held.
    always_comb begin
        head_s = mem_q[rd_ptr_q];
        if (rst) begin
            out_op_a    = 32'd0;
            out_op_b    = 32'd0;
            out_rm      = 3'd0;
            out_a_nan   = 1'b0;
            out_b_nan   = 1'b0;
            out_illegal = 1'b0;
        end else begin
            out_op_a    = head_s.a;
            out_op_b    = head_s.b;
            out_rm      = head_s.rm;
            out_a_nan   = head_s.a_nan;
            out_b_nan   = head_s.b_nan;
            out_illegal = head_s.illegal;
        end
        issued_cnt = issued_q;
    end
endmodule

// File: tb/tb_fp_minmax_issue.sv
// Self-checking bench: two instances (DEPTH=2/CNT_W=16 and DEPTH=4/CNT_W=4)
// compared each cycle against queue-based reference models.
module tb_fp_minmax_issue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_op_a = 32'd0;
    logic [31:0] in_op_b = 32'd0;
    logic [2:0]  in_rm = 3'd0;
    logic        out_ready = 1'b0;

    logic        o0_in_ready, o0_out_valid, o0_a_nan, o0_b_nan, o0_illegal;
    logic [31:0] o0_op_a, o0_op_b;
    logic [2:0]  o0_rm;
    logic [15:0] o0_issued;
    logic        o1_in_ready, o1_out_valid, o1_a_nan, o1_b_nan, o1_illegal;
    logic [31:0] o1_op_a, o1_op_b;
    logic [2:0]  o1_rm;
    logic [3:0]  o1_issued;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
    } op_t;

    op_t q0[$];
    op_t q1[$];
    int  cnt0 = 0;
    int  cnt1 = 0;
    int  n_chk = 0;
    int  n_pass = 0;
    bit  last_acc0 = 1'b0;

    always #5 clk = ~clk;

    fp_minmax_issue #(.DEPTH(2), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o0_in_ready),
        .in_op_a(in_op_a), .in_op_b(in_op_b), .in_rm(in_rm),
        .out_valid(o0_out_valid), .out_ready(out_ready),
        .out_op_a(o0_op_a), .out_op_b(o0_op_b), .out_rm(o0_rm),
        .out_a_nan(o0_a_nan), .out_b_nan(o0_b_nan), .out_illegal(o0_illegal),
        .issued_cnt(o0_issued)
    );

    fp_minmax_issue #(.DEPTH(4), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o1_in_ready),
        .in_op_a(in_op_a), .in_op_b(in_op_b), .in_rm(in_rm),
        .out_valid(o1_out_valid), .out_ready(out_ready),
        .out_op_a(o1_op_a), .out_op_b(o1_op_b), .out_rm(o1_rm),
        .out_a_nan(o1_a_nan), .out_b_nan(o1_b_nan), .out_illegal(o1_illegal),
        .issued_cnt(o1_issued)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic bit ref_nan(input logic [31:0] f);
        int unsigned expo;
        expo = (f >> 23) & 32'hFF;
        return (expo == 255) && ((f & 32'h007F_FFFF) != 0);
    endfunction

    task automatic cmp_inst(input string p, input int depth, input int size, input op_t h,
                            input int exp_cnt, input logic rdy, input logic vld,
                            input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                            input logic an, input logic bn, input logic il, input logic [31:0] ic);
        if (rst) begin
            check({p, "_rst_ready"}, {31'd0, rdy}, 32'd0);
            check({p, "_rst_valid"}, {31'd0, vld}, 32'd0);
            check({p, "_rst_a"}, a, 32'd0);
            check({p, "_rst_b"}, b, 32'd0);
            check({p, "_rst_flags"}, {26'd0, rm, an, bn, il}, 32'd0);
            check({p, "_rst_cnt"}, ic, 32'd0);
        end else begin
            check({p, "_in_ready"}, {31'd0, rdy}, {31'd0, size < depth});
            check({p, "_out_valid"}, {31'd0, vld}, {31'd0, size > 0});
            check({p, "_issued"}, ic, 32'(exp_cnt));
            if (size > 0) begin
                check({p, "_op_a"}, a, h.a);
                check({p, "_op_b"}, b, h.b);
                check({p, "_rm"}, {29'd0, rm}, {29'd0, h.rm});
                check({p, "_a_nan"}, {31'd0, an}, {31'd0, ref_nan(h.a)});
                check({p, "_b_nan"}, {31'd0, bn}, {31'd0, ref_nan(h.b)});
                check({p, "_illegal"}, {31'd0, il}, {31'd0, h.rm > 3'd1});
            end
        end
    endtask

    task automatic compare();
        op_t h0, h1;
        h0 = '{32'd0, 32'd0, 3'd0};
        h1 = '{32'd0, 32'd0, 3'd0};
        if (q0.size() > 0) h0 = q0[0];
        if (q1.size() > 0) h1 = q1[0];
        cmp_inst("d0", 2, q0.size(), h0, cnt0 % 65536, o0_in_ready, o0_out_valid,
                 o0_op_a, o0_op_b, o0_rm, o0_a_nan, o0_b_nan, o0_illegal, {16'd0, o0_issued});
        cmp_inst("d1", 4, q1.size(), h1, cnt1 % 16, o1_in_ready, o1_out_valid,
                 o1_op_a, o1_op_b, o1_rm, o1_a_nan, o1_b_nan, o1_illegal, {28'd0, o1_issued});
    endtask

    // One clock: predict handshakes from model state, advance the model, compare.
    task automatic tick();
        bit acc0, pop0, acc1, pop1;
        acc0 = !rst && in_valid && (q0.size() < 2);
        pop0 = !rst && out_ready && (q0.size() > 0);
        acc1 = !rst && in_valid && (q1.size() < 4);
        pop1 = !rst && out_ready && (q1.size() > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            q0.delete(); q1.delete();
            cnt0 = 0; cnt1 = 0;
        end else begin
            if (pop0) begin void'(q0.pop_front()); cnt0++; end
            if (pop1) begin void'(q1.pop_front()); cnt1++; end
            if (acc0) q0.push_back('{in_op_a, in_op_b, in_rm});
            if (acc1) q1.push_back('{in_op_a, in_op_b, in_rm});
        end
        last_acc0 = acc0;
        compare();
    endtask

    task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        in_valid = 1'b1; in_op_a = a; in_op_b = b; in_rm = rm;
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       r = {r[31], 8'hFF, (r[22:0] == 23'd0) ? 23'd1 : r[22:0]};
            1:       r = {r[31], 8'hFF, 23'd0};
            default: r = r;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] rand_rm();
        return ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_rst_d0", {31'd0, o0_in_ready}, 32'd1);
        check("ready_after_rst_d1", {31'd0, o1_in_ready}, 32'd1);
    endtask

    initial begin
        tick();
        do_reset();

        // single operation
        out_ready = 1'b1;
        offer(32'h3F80_0000, 32'h4000_0000, 3'b001);
        tick();
        in_valid = 1'b0;
        check("single_valid", {31'd0, o0_out_valid}, 32'd1);
        check("single_a", o0_op_a, 32'h3F80_0000);
        check("single_flags", {29'd0, o0_a_nan, o0_b_nan, o0_illegal}, 32'd0);
        tick();
        check("single_cnt", {16'd0, o0_issued}, 32'd1);
        check("single_empty", {31'd0, o0_out_valid}, 32'd0);

        // fill and stall
        out_ready = 1'b0;
        offer(32'h1111_1111, 32'h2222_2222, 3'b000); tick();
        offer(32'h3333_3333, 32'h4444_4444, 3'b001); tick();
        check("full_ready", {31'd0, o0_in_ready}, 32'd0);
        offer(32'h5555_5555, 32'h6666_6666, 3'b000); tick();
        out_ready = 1'b1; tick();
        check("stall_ready_back", {31'd0, o0_in_ready}, 32'd1);
        check("stall_order", o0_op_a, 32'h3333_3333);
        out_ready = 1'b0; tick();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // streaming
        begin
            int base;
            base = cnt0;
            for (int i = 0; i < 10; i++) begin
                offer(rand_fp(), rand_fp(), rand_rm());
                tick();
            end
            in_valid = 1'b0;
            tick();
            check("stream_cnt", {16'd0, o0_issued}, 32'((base + 10) % 65536));
        end

        // flags
        out_ready = 1'b0;
        offer(32'h7FC0_0000, 32'hFF80_0000, 3'b010);
        tick();
        in_valid = 1'b0;
        check("flag_a_nan", {31'd0, o0_a_nan}, 32'd1);
        check("flag_b_nan", {31'd0, o0_b_nan}, 32'd0);
        check("flag_illegal", {31'd0, o0_illegal}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("flag_popped", {31'd0, o0_out_valid}, 32'd0);

        // reset mid-operation with a push pending
        out_ready = 1'b0;
        offer(32'hAAAA_0001, 32'h0, 3'b000); tick();
        offer(32'hAAAA_0002, 32'h0, 3'b001); tick();
        do_reset();
        check("midrst_valid", {31'd0, o0_out_valid}, 32'd0);
        check("midrst_cnt", {16'd0, o0_issued}, 32'd0);
        in_valid = 1'b0;
        tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (!in_valid || last_acc0) begin
                in_op_a = rand_fp(); in_op_b = rand_fp(); in_rm = rand_rm();
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
            rst = 1'b0;
        end

        // counter wrap on the 4-bit instance
        in_valid = 1'b0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            offer(rand_fp(), rand_fp(), rand_rm());
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("wrap_cnt4", {28'd0, o1_issued}, 32'd1);
        check("wrap_cnt16", {16'd0, o0_issued}, 32'd17);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fp_minmax_issue.md
FP_MINMAX_ISSUE -- requirements
Module: fp_minmax_issue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 2, giving the number of entries in the operand buffer; only 2 and 4 are legal.
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the width of the issued-operation counter.
REQ-003 The module SHALL have these ports:
  clk  in  1  clock; one clock domain, all state on the rising edge
  rst  in  1  reset, synchronous, active-high
  in_valid  in  1  upstream has an operation
  in_ready  out  1  buffer can accept an operation
  in_op_a  in  32  first operand, IEEE-754 single
  in_op_b  in  32  second operand, IEEE-754 single
  in_rm  in  3  operation select: 000 = min, 001 = max
  out_valid  out  1  head entry is valid for the min/max stage
  out_ready  in  1  min/max stage consumes the head entry
  out_op_a  out  32  head first operand
  out_op_b  out  32  head second operand
  out_rm  out  3  head operation select
  out_a_nan  out  1  out_op_a is NaN
  out_b_nan  out  1  out_op_b is NaN
  out_illegal  out  1  out_rm is neither 000 nor 001
  issued_cnt  out  CNT_W  number of operations popped since reset

Function
REQ-004 An operation SHALL be accepted (push) on a rising edge where in_valid && in_ready.
REQ-005 An operation SHALL be popped on a rising edge where out_valid && out_ready.
REQ-006 The buffer SHALL be FIFO-ordered, with DEPTH entries, a wrapping write pointer, a wrapping read pointer and an occupancy count in the range 0..DEPTH.
REQ-007 in_ready SHALL be 1 exactly when count < DEPTH and rst is 0; it is decoded from the registered count only.
REQ-008 in_ready SHALL NOT depend combinationally on out_ready, so a pop in a full cycle does not allow a push in that same cycle.
REQ-009 out_valid SHALL be 1 exactly when count > 0.
REQ-010 out_op_a, out_op_b and out_rm SHALL be driven from the storage entry at the read pointer.
REQ-011 Latency SHALL be 1 cycle: an operation pushed into an empty buffer appears on the outputs, with out_valid = 1, in the cycle after the push edge; there is no bypass path.
REQ-012 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-013 Simultaneous push and pop with count = 0 cannot occur, because out_valid = 0; only the push takes effect.
REQ-014 A pointer at DEPTH-1 SHALL wrap to 0 on advance.
REQ-015 While out_valid = 1 and out_ready = 0, out_op_a, out_op_b, out_rm and the flag outputs SHALL hold stable.
REQ-016 out_a_nan SHALL be 1 exactly when out_op_a[30:23] = 8'hFF and out_op_a[22:0] != 0; out_b_nan SHALL follow the same rule on out_op_b.
REQ-017 The NaN flags SHALL be computed at push time and stored with the entry, so they are not recomputed on the output path.
REQ-018 out_illegal SHALL be 1 exactly when out_rm is neither 000 nor 001, computed at push time and stored with the entry.
REQ-019 Operations with an illegal out_rm SHALL still be issued normally; the flag is informational only.
REQ-020 issued_cnt SHALL increment by 1 on every pop.
REQ-021 issued_cnt SHALL wrap from 2^CNT_W - 1 to 0 with no saturation.
REQ-022 in_valid with in_ready = 0 SHALL have no effect; upstream holds its operation.

Reset
REQ-023 While rst = 1 at a clock edge: count, both pointers and issued_cnt SHALL be cleared to 0.
REQ-024 While rst = 1 at a clock edge: out_valid and in_ready SHALL read 0.
REQ-025 While rst = 1 at a clock edge: out_op_a, out_op_b, out_rm and all flag outputs SHALL read 0.
REQ-026 Reset SHALL take priority over a simultaneous push or pop.
REQ-027 Any entries buffered when reset is asserted mid-operation SHALL be discarded.
REQ-028 in_ready SHALL return to 1 in the first cycle in which rst = 0.

Verification
REQ-029 Single operation: push A = 3F800000, B = 40000000, rm = 001 with out_ready = 1 -> next cycle out_valid = 1 with the same values and no flags set; after the pop, count = 0 and issued_cnt = 1.
REQ-030 Fill and stall: push 3 back-to-back operations with out_ready = 0 and DEPTH = 2 -> in_ready = 0 after 2 pushes and the third operation is held upstream. Then raise out_ready for one cycle -> in_ready = 1 the following cycle and the outputs keep FIFO order.
REQ-031 Streaming: in_valid = 1 and out_ready = 1 continuously for 10 operations -> one pop per cycle after the first and count stays at 1. The pointers wrap, and issued_cnt = 10.
REQ-032 Flags: push A = 7FC00000, B = FF800000, rm = 010 -> out_a_nan = 1, out_b_nan = 0 (infinity), out_illegal = 1, and the entry still pops normally.
REQ-033 Reset mid-operation: 2 entries buffered, then rst = 1 for 1 cycle -> out_valid = 0, count = 0, issued_cnt = 0, and in_ready = 1 the cycle after rst falls.
REQ-034 Counter wrap: with CNT_W = 4, perform 17 pops -> issued_cnt = 1.
